uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Frame controller sitting directly behind the UART receiver (uartRx).
//  Consumes its symbol stream (symbol/newSymbol strobe) and parses frames: SOF, LEN, LEN payload bytes, optional CHK.
//  Forwards payload bytes downstream with valid/last strobes and reports frame completion or error.
//  An inter-symbol timeout, derived from baud rate, aborts stalled frames.
// PARAMETERS
//  CLK_FREQ      50_000_000  system clock frequency, Hz
//  BAUD_RATE     9600        UART baud rate; sets timeout granularity
//  MSG_BITS      8           symbol width; LEN field is also MSG_BITS wide
//  SOF           8'hA5       start-of-frame symbol value (MSG_BITS wide)
//  MAX_LEN       64          max payload length; 1 <= MAX_LEN <= 2**MSG_BITS-1
//  TIMEOUT_SYMS  4           idle symbol-times tolerated inside a frame
// PORTS
//  clk          in   1         system clock
//  rst          in   1         synchronous reset, active-high
//  symbol_i     in   MSG_BITS  received symbol from uartRx
//  newSymbol_i  in   1         1-cycle strobe: symbol_i valid
//  data_o       out  MSG_BITS  payload byte
//  dataValid_o  out  1         1-cycle strobe: data_o valid
//  dataLast_o   out  1         qualifies dataValid_o: last payload byte
//  frameLen_o   out  MSG_BITS  LEN of current/last frame, held until next LEN
//  frameDone_o  out  1         1-cycle pulse: frame accepted
//  frameErr_o   out  1         1-cycle pulse: frame aborted
//  errCode_o    out  2         0 none, 1 bad LEN, 2 timeout, 3 checksum; held until next frameErr_o/frameDone_o
//  busy_o       out  1         high whenever state != IDLE
// BEHAVIOUR
//  - Single clock domain clk; rst synchronous, active-high. Reset: all outputs 0, state IDLE, counters 0.
//  - rst mid-frame: frame dropped silently, no frameErr_o pulse.
//  - FSM: IDLE -> LEN -> PAYLOAD -> (CHK) -> IDLE.
//    IDLE: newSymbol_i with symbol_i==SOF -> LEN. Any other symbol is ignored.
//    LEN: LEN==0 or LEN>MAX_LEN -> frameErr_o, errCode 1, IDLE. Otherwise latch frameLen_o, cnt<=0, -> PAYLOAD.
//    PAYLOAD: each symbol -> data_o, dataValid_o. On cnt==LEN-1, assert dataLast_o, then -> CHK (macro) or IDLE with frameDone_o.
//  - Latency: dataValid_o/dataLast_o, frameDone_o and frameErr_o are registered and appear 1 cycle after the causing newSymbol_i.
//  - frameDone_o coincides with the last-byte dataValid_o (no macro) or follows the CHK symbol by 1 cycle.
//  - Timeout: per-symbol-time tick = CLK_FREQ/BAUD_RATE*(MSG_BITS+2) cycles.
//    Tick counter and symbol counter reset on every newSymbol_i and in IDLE.
//    At TIMEOUT_SYMS ticks in a non-IDLE state: frameErr_o, errCode 2, -> IDLE.
//  - Simultaneous newSymbol_i and timeout expiry: symbol wins, timeout discarded.
//  - SOF value inside LEN/PAYLOAD is treated as data (no resync).
//  - Downstream has no backpressure; it must discard payload of a frame that ends in frameErr_o.
// CONFIGURATION
//  UART_FRAME_CHKSUM_EN defined:
//    CHK state is present. CHK symbol = XOR of LEN and all payload bytes.
//    On match: frameDone_o. On mismatch: frameErr_o, errCode 3. Either way -> IDLE.
//  UART_FRAME_CHKSUM_EN undefined:
//    No CHK state, no XOR register. errCode 3 is never produced.
// STRUCTURE
//  Package uart_pkg: FSM state encoding, errCode constants (ERR_NONE/LEN/TIMEOUT/CHK), default SOF.
//  Sub-module uart_timeout_cnt: symbol-time prescaler plus tick counter; inputs clear/enable, output expired.
// TESTING
//  1 A5 03 11 22 33 (no macro) -> data 11,22,33; last on 33; frameDone_o; frameLen_o=3.
//  2 Macro on, A5 03 11 22 33 03 -> frameDone_o. Same frame with CHK=04 -> frameErr_o, errCode 3.
//  3 A5 00, and A5 41 with MAX_LEN=64 -> frameErr_o, errCode 1, no dataValid_o.
//  4 A5 02 11, then silence > 4 symbol-times -> frameErr_o, errCode 2, busy_o=0.
//    Expiry coincident with a byte -> no error.
//  5 Garbage 00 FF 5A then A5 01 7E -> garbage ignored, single-byte frame with dataLast_o.
//  6 rst asserted after 2nd payload byte -> next cycle all outputs 0, IDLE, no frameErr_o; next frame parses cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART frame controller.
// FSM state encoding, error codes, default start-of-frame symbol and the
// symbol-time helper used to size the inter-symbol timeout.
// The CHK state only exists when UART_FRAME_CHKSUM_EN is defined.
package uart_pkg;

    // Frame parser states; ST_CHK is only part of the checksum build.
`ifdef UART_FRAME_CHKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } frame_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } frame_state_t;
`endif

    // errCode_o values.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CHK     = 2'd3;

    // Start-of-frame symbol used when the instantiation does not override it.
    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

    // Clock cycles in one UART symbol time: start + data bits + stop.
    function automatic int unsigned symbol_time_cycles(
        input int unsigned clk_freq,
        input int unsigned baud_rate,
        input int unsigned msg_bits
    );
        return (clk_freq / baud_rate) * (msg_bits + 2);
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: inter-symbol timeout.
// A prescaler divides the clock down to one tick per symbol time; a tick
// counter then counts symbol times. expired is high once TIMEOUT_SYMS ticks
// have elapsed since the last clear and stays high (saturated) until cleared.
module uart_timeout_cnt #(
    parameter int unsigned TICK_CYCLES  = 52080,
    parameter int unsigned TIMEOUT_SYMS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_SYMS + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LIMIT = TW'(TIMEOUT_SYMS);

    logic [PW-1:0] prescale_q;
    logic [TW-1:0] ticks_q;

    // Prescaler and symbol-time counter; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prescale_q <= '0;
            ticks_q    <= '0;
        end else if (enable && !expired) begin
            if (prescale_q == PRE_LAST) begin
                prescale_q <= '0;
                ticks_q    <= ticks_q + TW'(1);
            end else begin
                prescale_q <= prescale_q + PW'(1);
            end
        end
    end

    assign expired = (ticks_q == TICK_LIMIT);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame parser behind the UART receiver.
// Frame format: SOF, LEN, LEN payload bytes and, when the build macro
// UART_FRAME_CHKSUM_EN is defined, a trailing CHK symbol equal to the XOR of
// LEN and all payload bytes. Without the macro there is no CHK state and no
// checksum register.
//
// Downstream interface: dataValid_o is a one-cycle strobe qualifying data_o,
// dataLast_o only has meaning while dataValid_o is high. There is no ready:
// the consumer must accept every strobe, and must drop the payload it has
// collected for a frame that ends with frameErr_o instead of frameDone_o.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned         CLK_FREQ     = 50_000_000,
    parameter int unsigned         BAUD_RATE    = 9600,
    parameter int unsigned         MSG_BITS     = 8,
    parameter logic [MSG_BITS-1:0] SOF          = MSG_BITS'(DEFAULT_SOF),
    parameter int unsigned         MAX_LEN      = 64,
    parameter int unsigned         TIMEOUT_SYMS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MSG_BITS-1:0] symbol_i,
    input  logic                newSymbol_i,
    output logic [MSG_BITS-1:0] data_o,
    output logic                dataValid_o,
    output logic                dataLast_o,
    output logic [MSG_BITS-1:0] frameLen_o,
    output logic                frameDone_o,
    output logic                frameErr_o,
    output logic [1:0]          errCode_o,
    output logic                busy_o,
    output frame_state_t        dbg_state
);

    localparam int unsigned TICK_CYCLES = symbol_time_cycles(CLK_FREQ, BAUD_RATE, MSG_BITS);
    localparam logic [MSG_BITS-1:0] MAX_LEN_W = MSG_BITS'(MAX_LEN);
    localparam logic [MSG_BITS-1:0] ONE_W     = MSG_BITS'(1);

    frame_state_t state_q, state_d;

    logic [MSG_BITS-1:0] cnt_q, cnt_d;
    logic [MSG_BITS-1:0] data_d, len_d;
    logic                valid_d, last_d, done_d, err_d;
    logic [1:0]          code_d;

`ifdef UART_FRAME_CHKSUM_EN
    logic [MSG_BITS-1:0] chk_q, chk_d;
`endif

    logic len_ok;
    logic last_byte;
    logic expired;

    // A LEN field is usable when it is non-zero and within the payload limit.
    assign len_ok    = (symbol_i != '0) && (symbol_i <= MAX_LEN_W);
    // Byte counter sits on the final payload index.
    assign last_byte = (cnt_q == (frameLen_o - ONE_W));

    // Timeout counts only inside a frame; every symbol restarts it.
    uart_timeout_cnt #(
        .TICK_CYCLES  (TICK_CYCLES),
        .TIMEOUT_SYMS (TIMEOUT_SYMS)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (newSymbol_i || (state_q == ST_IDLE)),
        .enable  (state_q != ST_IDLE),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a symbol arriving together with expiry wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (newSymbol_i && (symbol_i == SOF)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (newSymbol_i) begin
                    state_d = len_ok ? ST_PAYLOAD : ST_IDLE;
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (newSymbol_i) begin
                    if (last_byte) begin
`ifdef UART_FRAME_CHKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef UART_FRAME_CHKSUM_EN
            ST_CHK: begin
                if (newSymbol_i || expired) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic: next values of the registered outputs and counters.
    always_comb begin
        data_d  = data_o;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = errCode_o;
        len_d   = frameLen_o;
        cnt_d   = cnt_q;
`ifdef UART_FRAME_CHKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
            end
            ST_LEN: begin
                if (newSymbol_i) begin
                    if (len_ok) begin
                        len_d = symbol_i;
                        cnt_d = '0;
`ifdef UART_FRAME_CHKSUM_EN
                        chk_d = symbol_i;
`endif
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_LEN;
                    end
                end else if (expired) begin
                    err_d  = 1'b1;
                    code_d = ERR_TIMEOUT;
                end
            end
            ST_PAYLOAD: begin
                if (newSymbol_i) begin
                    data_d  = symbol_i;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + ONE_W;
`ifdef UART_FRAME_CHKSUM_EN
                    chk_d   = chk_q ^ symbol_i;
`endif
                    if (last_byte) begin
                        last_d = 1'b1;
`ifndef UART_FRAME_CHKSUM_EN
                        done_d = 1'b1;
                        code_d = ERR_NONE;
`endif
                    end
                end else if (expired) begin
                    err_d  = 1'b1;
                    code_d = ERR_TIMEOUT;
                end
            end
`ifdef UART_FRAME_CHKSUM_EN
            ST_CHK: begin
                if (newSymbol_i) begin
                    if (symbol_i == chk_q) begin
                        done_d = 1'b1;
                        code_d = ERR_NONE;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                end else if (expired) begin
                    err_d  = 1'b1;
                    code_d = ERR_TIMEOUT;
                end
            end
`endif
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Output and counter registers; reset drops any frame in flight silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o      <= '0;
            dataValid_o <= 1'b0;
            dataLast_o  <= 1'b0;
            frameDone_o <= 1'b0;
            frameErr_o  <= 1'b0;
            errCode_o   <= ERR_NONE;
            frameLen_o  <= '0;
            cnt_q       <= '0;
        end else begin
            data_o      <= data_d;
            dataValid_o <= valid_d;
            dataLast_o  <= last_d;
            frameDone_o <= done_d;
            frameErr_o  <= err_d;
            errCode_o   <= code_d;
            frameLen_o  <= len_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef UART_FRAME_CHKSUM_EN
    // Running XOR of LEN and payload bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    assign busy_o    = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: self-checking bench for uart_rx_frame_ctrl.
// Frames are described at frame level (LEN, payload, gaps, stall point,
// checksum corruption) and the expected output events are computed from
// those descriptions. Honours UART_FRAME_CHKSUM_EN like the design.
module tb_uart_rx_frame_ctrl;
  import uart_pkg::*;

  localparam int CLK_FREQ     = 1000;
  localparam int BAUD_RATE    = 100;
  localparam int MSG_BITS     = 8;
  localparam int MAX_LEN      = 64;
  localparam int TIMEOUT_SYMS = 4;
  localparam logic [7:0] SOF_V = 8'hA5;
  localparam int SYM_CYCLES = (CLK_FREQ / BAUD_RATE) * (MSG_BITS + 2);
  localparam int IDLE_LIMIT = TIMEOUT_SYMS * SYM_CYCLES;
`ifdef UART_FRAME_CHKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]   symbol;
  logic         new_symbol;
  logic [7:0]   data;
  logic         data_valid;
  logic         data_last;
  logic [7:0]   frame_len;
  logic         frame_done;
  logic         frame_err;
  logic [1:0]   err_code;
  logic         busy;
  frame_state_t dbg_state;

  uart_rx_frame_ctrl #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .MSG_BITS     (MSG_BITS),
    .SOF          (SOF_V),
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_SYMS (TIMEOUT_SYMS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .symbol_i    (symbol),
    .newSymbol_i (new_symbol),
    .data_o      (data),
    .dataValid_o (data_valid),
    .dataLast_o  (data_last),
    .frameLen_o  (frame_len),
    .frameDone_o (frame_done),
    .frameErr_o  (frame_err),
    .errCode_o   (err_code),
    .busy_o      (busy),
    .dbg_state   (dbg_state)
  );

  // scoreboard: event = {valid, last, done, err, code[1:0], data[7:0]}
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  logic [7:0]  pay_q[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_len = 0;
  logic [1:0]  exp_code = 2'b00;

  always @(negedge clk) begin
    if (data_valid || frame_done || frame_err)
      obs_q.push_back({data_valid, data_last, frame_done, frame_err,
                       (frame_done || frame_err) ? err_code : 2'b00,
                       data_valid ? data : 8'h00});
  end

  // driver: one symbol strobe, then gap idle clock edges
  task automatic send_sym(input logic [7:0] b, input int gap);
    symbol = b;
    new_symbol = 1'b1;
    @(posedge clk); #1;
    new_symbol = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  // frame driver + reference model. stall_at: symbol index followed by a
  // gap longer than the timeout; edge_at: symbol index followed by a gap of
  // exactly the timeout (next symbol lands on expiry and must win).
  task automatic send_frame(input logic [7:0] len_f, input int gap_max, input int stall_at,
                            input int edge_at, input logic [7:0] chk_mask);
    logic [7:0] syms[$];
    logic [7:0] x;
    int n;
    int g;
    bit stalled;
    if (len_f == 8'h00 || int'(len_f) > MAX_LEN) begin
      send_sym(SOF_V, $urandom_range(0, gap_max));
      send_sym(len_f, 1);
      exp_q.push_back({4'b0001, ERR_LEN, 8'h00});
      exp_code = ERR_LEN;
      return;
    end
    syms.push_back(SOF_V);
    syms.push_back(len_f);
    x = len_f;
    for (int i = 0; i < int'(len_f); i++) begin
      x = x ^ pay_q[i];
      syms.push_back(pay_q[i]);
    end
    if (CHK_ON) syms.push_back(x ^ chk_mask);
    n = syms.size();
    stalled = (stall_at >= 0) && (stall_at < n - 1);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) g = 1;
      else if (stalled && k == stall_at) g = IDLE_LIMIT + 1 + int'($urandom_range(0, 20));
      else if (k == edge_at) g = IDLE_LIMIT;
      else g = $urandom_range(0, gap_max);
      send_sym(syms[k], g);
      if (stalled && k == stall_at) break;
    end
    // expected events
    if (!stalled || stall_at >= 1) exp_len = int'(len_f);
    for (int i = 0; i < int'(len_f); i++) begin
      if (!stalled || i + 2 <= stall_at)
        exp_q.push_back({1'b1, (i == int'(len_f) - 1), (i == int'(len_f) - 1) && !CHK_ON,
                         1'b0, 2'b00, pay_q[i]});
    end
    if (stalled) begin
      exp_q.push_back({4'b0001, ERR_TIMEOUT, 8'h00});
      exp_code = ERR_TIMEOUT;
    end else if (CHK_ON && chk_mask != 8'h00) begin
      exp_q.push_back({4'b0001, ERR_CHK, 8'h00});
      exp_code = ERR_CHK;
    end else begin
      if (CHK_ON) exp_q.push_back({4'b0010, ERR_NONE, 8'h00});
      exp_code = ERR_NONE;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    new_symbol = 1'b0;
    symbol = 8'h00;
    repeat (3) @(posedge clk); #1;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", data_valid); end
    checks++; if (data_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", data_last); end
    checks++; if (frame_len !== 8'h00) begin failures++; $display("FAIL reset_len got=%h want=00", frame_len); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", frame_done); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", frame_err); end
    checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL reset_code got=%0d want=0", err_code); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    @(posedge clk); #1;
    obs_q.delete();
  endtask

  task automatic test_basic();
    logic [13:0] e, o;
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h03, 2, -1, -1, 8'h00);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL basic_event got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (frame_len !== 8'h03) begin failures++; $display("FAIL basic_len got=%h want=03", frame_len); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b want=0", busy); end
  endtask

  task automatic test_latency();
    send_sym(SOF_V, 0);
    send_sym(8'h01, 0);
    send_sym(8'h5C, 0);
    checks++; if (data_valid !== 1'b1 || data !== 8'h5C || data_last !== 1'b1) begin
      failures++; $display("FAIL latency_data got=%b/%h/%b want=1/5c/1", data_valid, data, data_last); end
    checks++; if (frame_done !== !CHK_ON) begin failures++; $display("FAIL latency_done got=%b want=%b", frame_done, !CHK_ON); end
    if (CHK_ON) begin
      send_sym(8'h5D, 0);
      checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL latency_chk_done got=%b want=1", frame_done); end
    end
    repeat (3) @(posedge clk); #1;
    exp_len = 1; exp_code = ERR_NONE;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bad_len();
    logic [13:0] e, o;
    pay_q.delete();
    send_frame(8'h00, 2, -1, -1, 8'h00);
    send_frame(8'h41, 2, -1, -1, 8'h00);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL badlen_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL badlen_event got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (err_code !== ERR_LEN) begin failures++; $display("FAIL badlen_code got=%0d want=1", err_code); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL badlen_busy got=%b want=0", busy); end
  endtask

  task automatic test_timeout();
    logic [13:0] e, o;
    pay_q = '{8'h11, 8'h22};
    send_frame(8'h02, 1, 2, -1, 8'h00);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b want=0", busy); end
    checks++; if (err_code !== ERR_TIMEOUT) begin failures++; $display("FAIL timeout_code got=%0d want=2", err_code); end
    pay_q = '{8'h11, 8'h22};
    send_frame(8'h02, 1, -1, 2, 8'h00);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL timeout_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL timeout_event got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_garbage();
    logic [13:0] e, o;
    send_sym(8'h00, 1);
    send_sym(8'hFF, 0);
    send_sym(8'h5A, 2);
    pay_q = '{8'h7E};
    send_frame(8'h01, 1, -1, -1, 8'h00);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL garbage_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL garbage_event got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef UART_FRAME_CHKSUM_EN
  task automatic test_chksum();
    logic [13:0] e, o;
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h03, 1, -1, -1, 8'h00);
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h03, 1, -1, -1, 8'h07);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL chk_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL chk_event got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (err_code !== ERR_CHK) begin failures++; $display("FAIL chk_code got=%0d want=3", err_code); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [13:0] e, o;
    send_sym(SOF_V, 0);
    send_sym(8'h04, 1);
    send_sym(8'h11, 0);
    send_sym(8'h22, 0);
    exp_q.push_back({4'b1000, 2'b00, 8'h11});
    exp_q.push_back({4'b1000, 2'b00, 8'h22});
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (data !== 8'h00 || data_valid !== 1'b0 || data_last !== 1'b0) begin
      failures++; $display("FAIL midrst_data got=%h/%b/%b want=00/0/0", data, data_valid, data_last); end
    checks++; if (frame_len !== 8'h00 || err_code !== 2'b00) begin
      failures++; $display("FAIL midrst_len_code got=%h/%0d want=00/0", frame_len, err_code); end
    checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_flags got=%b/%b/%b want=0/0/0", frame_done, frame_err, busy); end
    rst = 1'b0;
    exp_len = 0; exp_code = ERR_NONE;
    repeat (3) @(posedge clk); #1;
    pay_q = '{8'hA5, 8'h3C};
    send_frame(8'h02, 1, -1, -1, 8'h00);
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL midrst_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL midrst_event got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [13:0] e, o;
    for (int f = 0; f < 4; f++) begin
      pay_q.delete();
      for (int i = 0; i <= f; i++) pay_q.push_back((i == 1) ? SOF_V : 8'($urandom_range(0, 255)));
      send_frame(8'(f + 1), 0, -1, -1, 8'h00);
    end
    repeat (4) @(posedge clk); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_event got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (frame_len !== 8'h04) begin failures++; $display("FAIL b2b_len got=%h want=04", frame_len); end
  endtask

  task automatic test_random();
    logic [13:0] e, o;
    logic [7:0] lf, mask, b;
    int n, stall, edge_i, ng;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        ng = $urandom_range(1, 3);
        for (int g = 0; g < ng; g++) begin
          b = 8'($urandom_range(0, 255));
          if (b == SOF_V) b = 8'h00;
          send_sym(b, $urandom_range(0, 3));
        end
      end
      case ($urandom_range(0, 9))
        0: lf = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
        1: lf = 8'($urandom_range(1, MAX_LEN));
        default: lf = 8'($urandom_range(1, 12));
      endcase
      pay_q.delete();
      for (int i = 0; i < int'(lf); i++) pay_q.push_back(8'($urandom_range(0, 255)));
      n = 2 + int'(lf) + int'(CHK_ON);
      stall = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 2)) : -1;
      edge_i = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 2)) : -1;
      if (edge_i == stall) edge_i = -1;
      mask = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(lf, 3, stall, edge_i, mask);
      repeat (4) @(posedge clk); #1;
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count frame=%0d got=%0d want=%0d", f, obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL rand_event frame=%0d got=%h want=%h", f, o, e); end
      end
      exp_q.delete(); obs_q.delete();
      checks++; if (int'(frame_len) != exp_len) begin failures++; $display("FAIL rand_len frame=%0d got=%0d want=%0d", f, frame_len, exp_len); end
      checks++; if (err_code !== exp_code) begin failures++; $display("FAIL rand_code frame=%0d got=%0d want=%0d", f, err_code, exp_code); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rand_busy frame=%0d got=%b want=0", f, busy); end
    end
  endtask

  initial begin
    rst = 1'b1;
    new_symbol = 1'b0;
    symbol = 8'h00;
    test_reset();
    test_basic();
    test_latency();
    test_bad_len();
    test_timeout();
    test_garbage();
`ifdef UART_FRAME_CHKSUM_EN
    test_chksum();
`endif
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
